// File: rtl/fen_decoder.sv
// rtl/fen_decoder.sv - streaming FEN parser with a 64-square nibble board emitter
// Optional placement checking (suppresses emission on error) under FEN_CHECK_EN.
module fen_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_valid,
    output logic        o_pos_valid,
    output logic [3:0]  o_pos_data,
    output logic        o_pos_sop,
    output logic        o_pos_eop,
    output logic        o_wtp,
    output logic [3:0]  o_castle,
    output logic [2:0]  o_ep,
    output logic [15:0] o_hmcount,
    output logic [15:0] o_fmcount
);

    typedef enum logic [2:0] {
        S_IDLE, S_PLACE, S_SIDE, S_CASTLE, S_EP, S_HALF, S_FULL
    } state_t;

    state_t     state, state_n, cur;

    logic [3:0] board [64];
    logic [6:0] wp, wp_n, wp_eff, wp_sum;
    logic [5:0] emit_idx;

    logic       restart, is_space, is_digit, is_place_digit, is_piece, is_file;
    logic       place_en, side_en, castle_en, ep_en, half_en, full_en;
    logic       trigger_raw, trigger;
    logic [3:0] piece, first_sq;

    function automatic logic [3:0] piece_code(input logic [7:0] c);
        case (c)
            "P":     piece_code = 4'h1;
            "N":     piece_code = 4'h2;
            "B":     piece_code = 4'h3;
            "R":     piece_code = 4'h4;
            "Q":     piece_code = 4'h5;
            "K":     piece_code = 4'h6;
            "p":     piece_code = 4'h9;
            "n":     piece_code = 4'hA;
            "b":     piece_code = 4'hB;
            "r":     piece_code = 4'hC;
            "q":     piece_code = 4'hD;
            "k":     piece_code = 4'hE;
            default: piece_code = 4'h0;
        endcase
    endfunction

    function automatic logic [15:0] dec_step(input logic [15:0] cnt, input logic [3:0] d);
        dec_step = cnt * 16'd10 + {12'd0, d};
    endfunction

    assign restart        = in_valid & in_sop;
    assign is_space       = (in_data == 8'h20);
    assign is_digit       = (in_data >= "0") && (in_data <= "9");
    assign is_place_digit = (in_data >= "1") && (in_data <= "8");
    assign is_file        = (in_data >= "a") && (in_data <= "h");
    assign piece          = piece_code(in_data);
    assign is_piece       = (piece != 4'h0);
    // A sop byte is always parsed as the first placement character.
    assign cur            = restart ? S_PLACE : state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (in_valid) begin
            state_n = cur;
            if (is_space) begin
                case (cur)
                    S_PLACE:  state_n = S_SIDE;
                    S_SIDE:   state_n = S_CASTLE;
                    S_CASTLE: state_n = S_EP;
                    S_EP:     state_n = S_HALF;
                    S_HALF:   state_n = S_FULL;
                    default:  state_n = cur;
                endcase
            end
            if (in_eop) state_n = S_IDLE;
        end
    end

    always_comb begin
        place_en  = 1'b0;
        side_en   = 1'b0;
        castle_en = 1'b0;
        ep_en     = 1'b0;
        half_en   = 1'b0;
        full_en   = 1'b0;
        if (in_valid && !is_space) begin
            case (cur)
                S_PLACE:  place_en  = 1'b1;
                S_SIDE:   side_en   = 1'b1;
                S_CASTLE: castle_en = 1'b1;
                S_EP:     ep_en     = 1'b1;
                S_HALF:   half_en   = 1'b1;
                S_FULL:   full_en   = 1'b1;
                default:  ;
            endcase
        end
        trigger_raw = in_valid && (cur == S_PLACE) && (is_space || in_eop);
    end

    always_comb begin
        wp_eff = restart ? 7'd0 : wp;
        wp_sum = wp_eff + {3'd0, in_data[3:0]};
        wp_n   = wp_eff;
        if (place_en) begin
            if (is_piece)
                wp_n = (wp_eff == 7'd64) ? 7'd64 : wp_eff + 7'd1;
            else if (is_place_digit)
                wp_n = (wp_sum > 7'd64) ? 7'd64 : wp_sum;
        end
    end

`ifdef FEN_CHECK_EN
    logic       err, err_n;
    logic [7:0] rank_end;

    always_comb begin
        err_n    = restart ? 1'b0 : err;
        rank_end = {1'b0, wp_eff[6:3], 3'b000} + 8'd8;
        if (place_en) begin
            if (in_data == "/") begin
                if ((wp_eff == 7'd0) || (wp_eff[2:0] != 3'd0)) err_n = 1'b1;
            end else if (is_place_digit) begin
                if ({1'b0, wp_sum} > rank_end) err_n = 1'b1;
            end else if (!is_piece) begin
                err_n = 1'b1;
            end
        end
        if (trigger_raw && (wp_n != 7'd64)) err_n = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= err_n;
    end

    assign trigger = trigger_raw && !err_n;
`else
    assign trigger = trigger_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= 7'd0;
            for (int i = 0; i < 64; i++) board[i] <= 4'h0;
        end else begin
            wp <= wp_n;
            if (restart)
                for (int i = 0; i < 64; i++) board[i] <= 4'h0;
            if (place_en && is_piece && !wp_eff[6])
                board[wp_eff[5:0]] <= piece;
        end
    end

    // Square 0 as it will stand after this edge, so beat 0 is valid on the first cycle.
    assign first_sq = (place_en && is_piece && (wp_eff == 7'd0)) ? piece :
                      (restart ? 4'h0 : board[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pos_valid <= 1'b0;
            o_pos_data  <= 4'h0;
            o_pos_sop   <= 1'b0;
            o_pos_eop   <= 1'b0;
            emit_idx    <= 6'd0;
        end else if (trigger) begin
            o_pos_valid <= 1'b1;
            o_pos_data  <= first_sq;
            o_pos_sop   <= 1'b1;
            o_pos_eop   <= 1'b0;
            emit_idx    <= 6'd0;
        end else if (restart || (o_pos_valid && (emit_idx == 6'd63))) begin
            o_pos_valid <= 1'b0;
            o_pos_data  <= 4'h0;
            o_pos_sop   <= 1'b0;
            o_pos_eop   <= 1'b0;
            emit_idx    <= 6'd0;
        end else if (o_pos_valid) begin
            o_pos_data  <= board[emit_idx + 6'd1];
            o_pos_sop   <= 1'b0;
            o_pos_eop   <= (emit_idx == 6'd62);
            emit_idx    <= emit_idx + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wtp     <= 1'b0;
            o_castle  <= 4'h0;
            o_ep      <= 3'd0;
            o_hmcount <= 16'd0;
            o_fmcount <= 16'd0;
        end else if (restart) begin
            o_wtp     <= 1'b0;
            o_castle  <= 4'h0;
            o_ep      <= 3'd0;
            o_hmcount <= 16'd0;
            o_fmcount <= 16'd0;
        end else begin
            if (side_en) begin
                if (in_data == "w")      o_wtp <= 1'b1;
                else if (in_data == "b") o_wtp <= 1'b0;
            end
            if (castle_en) begin
                if (in_data == "K") o_castle[3] <= 1'b1;
                if (in_data == "Q") o_castle[2] <= 1'b1;
                if (in_data == "k") o_castle[1] <= 1'b1;
                if (in_data == "q") o_castle[0] <= 1'b1;
            end
            // 'a'..'h' have low bits 1..7,0, so subtracting one yields the file index.
            if (ep_en && is_file) o_ep <= in_data[2:0] - 3'd1;
            if (half_en && is_digit) o_hmcount <= dec_step(o_hmcount, in_data[3:0]);
            if (full_en && is_digit) o_fmcount <= dec_step(o_fmcount, in_data[3:0]);
        end
    end

endmodule

// File: tb/tb_fen_decoder.sv
// tb/tb_fen_decoder.sv - scoreboard bench for fen_decoder
module tb_fen_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic        in_valid = 1'b0;
    logic        o_pos_valid;
    logic [3:0]  o_pos_data;
    logic        o_pos_sop;
    logic        o_pos_eop;
    logic        o_wtp;
    logic [3:0]  o_castle;
    logic [2:0]  o_ep;
    logic [15:0] o_hmcount;
    logic [15:0] o_fmcount;

    always #5 clk = ~clk;

    fen_decoder dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid),
        .o_pos_valid(o_pos_valid), .o_pos_data(o_pos_data),
        .o_pos_sop(o_pos_sop), .o_pos_eop(o_pos_eop),
        .o_wtp(o_wtp), .o_castle(o_castle), .o_ep(o_ep),
        .o_hmcount(o_hmcount), .o_fmcount(o_fmcount)
    );

    logic [5:0] exp_q [$];
    int         vectors = 0;
    int         miscompares = 0;
    int         beat_no = 0;
    logic [3:0] b_start [64];
    logic [3:0] b_kp    [64];
    logic [3:0] b_zero  [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Beat layout in the queue: {sop, eop, data}.
    always @(negedge clk) begin
        if (!rst && o_pos_valid) begin
            if (exp_q.size() == 0) begin
                check($sformatf("unexpected_beat_%0d", beat_no),
                      {o_pos_sop, o_pos_eop, o_pos_data}, 32'hFFFF);
            end else begin
                check($sformatf("beat_%0d", beat_no),
                      {o_pos_sop, o_pos_eop, o_pos_data}, exp_q.pop_front());
            end
            beat_no++;
        end
    end

    task automatic push_board(input logic [3:0] b [64]);
        for (int i = 0; i < 64; i++) exp_q.push_back({(i == 0), (i == 63), b[i]});
    endtask

    task automatic send_byte(input logic [7:0] c, input logic s, input logic e);
        in_data  = c;
        in_sop   = s;
        in_eop   = e;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = "/";
    endtask

    // Invalid cycles carry garbage with sop/eop high; the DUT must ignore them.
    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            in_sop   = 1'b1;
            in_eop   = 1'b1;
            in_data  = " ";
            @(posedge clk); #1;
        end
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask

    task automatic send_str(input string s, input logic first_sop, input logic last_eop, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], first_sop && (i == 0), last_eop && (i == s.len() - 1));
            if (gap > 0 && i != s.len() - 1) idle(gap);
        end
    endtask

    task automatic check_scalars(input string tag, input logic w, input logic [3:0] c,
                                 input logic [2:0] e, input logic [15:0] h, input logic [15:0] f);
        check({tag, "_wtp"}, o_wtp, w);
        check({tag, "_castle"}, o_castle, c);
        check({tag, "_ep"}, o_ep, e);
        check({tag, "_hm"}, o_hmcount, h);
        check({tag, "_fm"}, o_fmcount, f);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pos_valid"}, o_pos_valid, 0);
        check({tag, "_pos_data"}, o_pos_data, 0);
        check({tag, "_pos_sop"}, o_pos_sop, 0);
        check({tag, "_pos_eop"}, o_pos_eop, 0);
        check_scalars(tag, 1'b0, 4'h0, 3'd0, 16'd0, 16'd0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check({tag, "_beats_left"}, exp_q.size(), 0);
    endtask

    function automatic logic [3:0] back_rank(input int f);
        case (f)
            0, 7:    back_rank = 4'h4;
            1, 6:    back_rank = 4'h2;
            2, 5:    back_rank = 4'h3;
            3:       back_rank = 4'h5;
            default: back_rank = 4'h6;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            b_zero[i]  = 4'h0;
            b_kp[i]    = 4'h0;
            b_start[i] = 4'h0;
        end
        for (int i = 0; i < 8; i++) begin
            b_start[i]      = back_rank(i) | 4'h8;
            b_start[8 + i]  = 4'h9;
            b_start[48 + i] = 4'h1;
            b_start[56 + i] = back_rank(i);
        end
        b_kp[4]  = 4'hE;
        b_kp[27] = 4'h9;
        b_kp[28] = 4'h1;
        b_kp[60] = 4'h6;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        push_board(b_start);
        send_str("rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1", 1'b1, 1'b1, 0);
        check_scalars("start", 1'b1, 4'hF, 3'd0, 16'd0, 16'd1);
        wait_drain("start");

        push_board(b_kp);
        send_str("4k3/8/8/3pP3/8/8/8/4K3 b - d6 12 345", 1'b1, 1'b1, 2);
        check_scalars("kp_gap", 1'b0, 4'h0, 3'd3, 16'd12, 16'd345);
        wait_drain("kp_gap");

        push_board(b_zero);
        send_str("8/8/8/8/8/8/8/8 w - - 0 70000", 1'b1, 1'b1, 0);
        check_scalars("fm_wrap", 1'b1, 4'h0, 3'd0, 16'd0, 16'd4464);
        wait_drain("fm_wrap");

        // Second sop lands mid-emission: the old stream's tail is dropped.
        push_board(b_start);
        send_str("rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w", 1'b1, 1'b0, 0);
        idle(10);
        send_byte("4", 1'b1, 1'b0);
        check("abort_valid", o_pos_valid, 0);
        check("abort_wtp_cleared", o_wtp, 0);
        exp_q.delete();
        push_board(b_kp);
        send_str("k3/8/8/3pP3/8/8/8/4K3 b - d6 12 345", 1'b0, 1'b1, 0);
        check_scalars("after_abort", 1'b0, 4'h0, 3'd3, 16'd12, 16'd345);
        wait_drain("after_abort");

        push_board(b_zero);
        send_str("8/8/8/8/8/8/8/8 w KQ", 1'b1, 1'b0, 1);
        check("pre_rst_wtp", o_wtp, 1);
        check("pre_rst_castle", o_castle, 4'hC);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        send_str("8 b KQkq a3 9 9", 1'b0, 1'b1, 2);
        check_all_zero("idle_no_sop");
        idle(5);

`ifndef FEN_CHECK_EN
        push_board(b_zero);
`endif
        send_str("8/8/8/8/8/8/8/7 w - - 3 9", 1'b1, 1'b1, 0);
        check_scalars("short_place", 1'b1, 4'h0, 3'd0, 16'd3, 16'd9);
        wait_drain("short_place");

        idle(70);
        check("final_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fen_decoder.md
Name: fen_decoder

Overview:
- Streaming parser for a chess position in FEN (Forsyth-Edwards Notation) text.
- Accepts one ASCII byte per cycle, framed as a packet, and builds an internal 64-square board.
- After the piece-placement field ends, emits the board as a 64-beat nibble stream, one square per beat.
- Decodes the remaining FEN fields (side to move, castling rights, en-passant file, halfmove and fullmove counters) onto registered scalar outputs for the move-generator front end.

Parameters:
- None. Board size (64), square width (4) and counter width (16) are fixed.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  ASCII character
- in_sop  in  1  first byte of packet (qualified by in_valid)
- in_eop  in  1  last byte of packet (qualified by in_valid)
- in_valid  in  1  byte valid; no backpressure
- o_pos_valid  out  1  square beat valid
- o_pos_data  out  4  piece code of current square
- o_pos_sop  out  1  first square beat (a8)
- o_pos_eop  out  1  last square beat (h1)
- o_wtp  out  1  1 = white to play
- o_castle  out  4  castling rights: bit3 K, bit2 Q, bit1 k, bit0 q
- o_ep  out  3  en-passant file, a=0 .. h=7
- o_hmcount  out  16  halfmove clock
- o_fmcount  out  16  fullmove number

Behaviour:
- Reset: all outputs 0; parser state IDLE; board all empty; emitter idle.
- Beats with in_valid=0 are ignored. All outputs are registered.
- in_valid&in_sop, from any state: restart the packet.
  - Clear the board and all scalar outputs to 0.
  - Abort any in-progress emission; no eop is produced for the aborted stream.
  - Process the sop byte as the first PLACE character.
- In IDLE, valid bytes without sop are ignored.
- Parser states, advancing on each space (0x20): PLACE -> SIDE -> CASTLE -> EP -> HALF -> FULL. A space in FULL is ignored.
- in_valid&in_eop: process the byte, then go to IDLE.
- PLACE field:
  - Write pointer wp (0..64) starts at 0; square 0 = a8, 7 = h8, 8 = a7, ..., 63 = h1.
  - Piece letters write a code at wp, then wp++.
  - Piece codes: P=1, N=2, B=3, R=4, Q=5, K=6 for white; black is the same code with bit3 set (p=9 .. k=14); empty = 0.
  - Digit '1'..'8' leaves n squares empty and does wp += n in one cycle.
  - '/' and other characters are ignored.
  - wp saturates at 64; writes at wp >= 64 are dropped.
- Emission trigger: the space ending PLACE, or eop while in PLACE.
  - Starting the next cycle, emit 64 consecutive beats with o_pos_valid=1, squares 0..63 in order.
  - o_pos_sop on beat 0, o_pos_eop on beat 63.
  - Emission runs concurrently with parsing of later fields.
- SIDE: 'w' -> o_wtp=1; 'b' -> o_wtp=0.
- CASTLE: 'K','Q','k','q' set bits 3,2,1,0 respectively; '-' leaves 0.
- EP: file letter 'a'..'h' -> o_ep = letter-'a'; the rank digit is ignored. '-' leaves o_ep=0; consumers disambiguate using o_wtp and the board.
- HALF / FULL: each decimal digit updates count = count*10 + digit. Arithmetic is mod 2^16 (wraps). Non-digits are ignored.
- Scalar outputs update in the cycle after the consuming byte and hold until the next sop.

Optional Feature:
- Macro FEN_CHECK_EN.
- Defined: the block tracks a placement error, cleared at sop. The error is set if any of the following occurs:
  - a '/' arrives with wp not a nonzero multiple of 8;
  - a digit pushes wp past the current rank boundary;
  - wp != 64 at the emission trigger;
  - any non-FEN character appears in PLACE.
- With an error set, the 64-beat emission is suppressed entirely; scalar decoding is unaffected.
- Undefined: no checking; emission always occurs.

Test Plan:
- Start position "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1":
  - 64 beats; beat0=0xC, beat4=0xE, beats16..47=0, beat60=0x6, beat63=0x4; sop on beat0, eop on beat63.
  - Scalars: o_wtp=1, o_castle=0xF, o_ep=0, o_hmcount=0, o_fmcount=1.
- "4k3/8/8/3pP3/8/8/8/4K3 b - d6 12 345" -> o_wtp=0, o_castle=0, o_ep=3, o_hmcount=12, o_fmcount=345; beat27=0x9, beat28=0x1.
- Fullmove "70000" -> o_fmcount = 70000 mod 65536 = 4464.
- Second sop arrives mid-emission -> current stream ends without eop; the new packet emits a fresh, complete 64-beat stream.
- in_valid gaps between bytes plus rst asserted mid-packet -> gapped bytes are ignored; on reset all outputs return to 0 and the parser is in IDLE.
- FEN_CHECK_EN defined, placement "8/8/8/8/8/8/8/7" -> no o_pos_valid beats, scalars still decoded; the same input without the macro emits 64 zero beats.
